// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: word geometry, boot address and FSM states.
package program_loader_pkg;
  localparam int NBITS        = 32;
  localparam int MEMORY_DEPTH = 512;
  localparam int ADDR_W       = $clog2(MEMORY_DEPTH);
  localparam logic [NBITS-1:0] TEXT_BASE = 32'h0040_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/program_loader_if.sv
// Loader signal bundle: byte stream in, program RAM write port and boot control out.
interface program_loader_if import program_loader_pkg::*; ();
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NBITS-1:0]  mem_wdata;
  logic              cpu_hold;
  logic [NBITS-1:0]  boot_pc;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, boot_pc,
           busy, done, error, words_loaded
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, boot_pc,
           busy, done, error, words_loaded
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs incoming bytes little-endian into a 32-bit word; o_word_next already holds the byte on i_byte.
module program_loader_word_assembler import program_loader_pkg::*; (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_byte_en,
  input  logic [7:0]       i_byte,
  output logic [NBITS-1:0] o_word_next,
  output logic             o_word_full
);
  logic [NBITS-1:0] r_word;
  logic [1:0]       r_byte_idx;

  always_comb begin
    o_word_next = r_word;
    o_word_next[{r_byte_idx, 3'b000} +: 8] = i_byte;
  end

  assign o_word_full = i_byte_en && (r_byte_idx == 2'd3);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_word     <= '0;
      r_byte_idx <= 2'd0;
    end else if (i_clear) begin
      r_word     <= '0;
      r_byte_idx <= 2'd0;
    end else if (i_byte_en) begin
      r_word     <= o_word_next;
      r_byte_idx <= r_byte_idx + 2'd1;
    end
  end
endmodule

// File: rtl/program_loader.sv
// Program RAM writer: reads a 16-bit word count then instruction bytes, writes words from address 0,
// and holds the CPU until the image is complete.
//   state    | meaning
//   S_IDLE   | waiting for start after reset
//   S_LEN_LO | receiving word count low byte
//   S_LEN_HI | receiving word count high byte, validating it
//   S_DATA   | receiving instruction bytes
//   S_WRITE  | one-cycle RAM write of the assembled word
//   S_DONE   | image complete, CPU released
//   S_ERR    | word count too large, CPU held
module program_loader import program_loader_pkg::*; (
  input  logic            i_clk,
  input  logic            i_reset,
  program_loader_if.slave io_bus
);
  state_t            r_state;
  logic              r_rx_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [NBITS-1:0]  r_mem_wdata;
  logic              r_cpu_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W:0]   r_words_loaded;
  logic [15:0]       r_len;

  logic              w_accept;
  logic              w_clear;
  logic              w_byte_en;
  logic              w_word_full;
  logic [15:0]       w_len;
  logic [ADDR_W:0]   w_count_next;
  logic [NBITS-1:0]  w_word_next;

  assign w_accept     = io_bus.rx_valid && r_rx_ready;
  assign w_clear      = io_bus.start && (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_byte_en    = w_accept && (r_state == S_DATA);
  assign w_len        = {io_bus.rx_data, r_len[7:0]};
  assign w_count_next = r_words_loaded + (ADDR_W+1)'(1);

  program_loader_word_assembler u_asm (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_clear),
    .i_byte_en   (w_byte_en),
    .i_byte      (io_bus.rx_data),
    .o_word_next (w_word_next),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_rx_ready     <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_cpu_hold     <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= '0;
      r_len          <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (io_bus.start) begin
            r_state        <= S_LEN_LO;
            r_rx_ready     <= 1'b1;
            r_busy         <= 1'b1;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= io_bus.rx_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= io_bus.rx_data;
            if (w_len == 16'd0) begin
              r_state    <= S_DONE;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_cpu_hold <= 1'b0;
              r_done     <= 1'b1;
            end else if (w_len > 16'(MEMORY_DEPTH)) begin
              r_state    <= S_ERR;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_word_full) begin
            r_state     <= S_WRITE;
            r_rx_ready  <= 1'b0;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_words_loaded[ADDR_W-1:0];
            r_mem_wdata <= w_word_next;
          end
        end
        S_WRITE: begin
          r_words_loaded <= w_count_next;
          if (16'(w_count_next) == r_len) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_state    <= S_DATA;
            r_rx_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.rx_ready     = r_rx_ready;
  assign io_bus.mem_we       = r_mem_we;
  assign io_bus.mem_addr     = r_mem_addr;
  assign io_bus.mem_wdata    = r_mem_wdata;
  assign io_bus.cpu_hold     = r_cpu_hold;
  assign io_bus.boot_pc      = TEXT_BASE;
  assign io_bus.busy         = r_busy;
  assign io_bus.done         = r_done;
  assign io_bus.error        = r_error;
  assign io_bus.words_loaded = r_words_loaded;
endmodule
